// File: rtl/mshr_iss_q_if.sv
// rtl/mshr_iss_q_if.sv - allocate/issue/lookup bundle between the D-cache MSHR and its issue queue
// Messages are 2-bit codes: 0 NONE, 1 GET_S, 2 GET_M, 3 PUT_M.
interface mshr_iss_q_if #(
    parameter int NUM    = 4,
    parameter int TAG_W  = 13,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 64
);
    localparam int PTR_W = $clog2(NUM);
    localparam int CNT_W = $clog2(NUM + 1);

    logic              alloc_en_i;
    logic [TAG_W-1:0]  alloc_tag_i;
    logic [IDX_W-1:0]  alloc_idx_i;
    logic [DATA_W-1:0] alloc_data_i;
    logic [1:0]        alloc_message_i;
    logic              iss_ack_i;
    logic              iss_dty_i;
    logic              flush_i;

    logic              iss_en_o;
    logic              iss_st_en_o;
    logic              iss_evict_en_o;
    logic [TAG_W-1:0]  iss_tag_o;
    logic [IDX_W-1:0]  iss_idx_o;
    logic [DATA_W-1:0] iss_data_o;
    logic [1:0]        iss_message_o;
    logic [PTR_W-1:0]  iss_head_o;
    logic              hit_o;
    logic [DATA_W-1:0] hit_data_o;
    logic [1:0]        hit_message_o;
    logic              full_o;
    logic              empty_o;
    logic [CNT_W-1:0]  count_o;
    logic              ovf_o;

    modport master (
        output alloc_en_i, alloc_tag_i, alloc_idx_i, alloc_data_i, alloc_message_i,
        output iss_ack_i, iss_dty_i, flush_i,
        input  iss_en_o, iss_st_en_o, iss_evict_en_o, iss_tag_o, iss_idx_o, iss_data_o,
        input  iss_message_o, iss_head_o, hit_o, hit_data_o, hit_message_o,
        input  full_o, empty_o, count_o, ovf_o
    );

    modport slave (
        input  alloc_en_i, alloc_tag_i, alloc_idx_i, alloc_data_i, alloc_message_i,
        input  iss_ack_i, iss_dty_i, flush_i,
        output iss_en_o, iss_st_en_o, iss_evict_en_o, iss_tag_o, iss_idx_o, iss_data_o,
        output iss_message_o, iss_head_o, hit_o, hit_data_o, hit_message_o,
        output full_o, empty_o, count_o, ovf_o
    );
endinterface

// File: rtl/mshr_iss_q.sv
// rtl/mshr_iss_q.sv - MSHR issue queue: FIFO of GET_S/GET_M/PUT_M with forwarding, store merge and flush
// Circular buffer; head issues to the memory bus, tail accepts new misses/evictions.
module mshr_iss_q #(
    parameter int NUM    = 4,
    parameter int TAG_W  = 13,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(NUM + 1)
) (
    input  logic            clk,
    input  logic            rst,
    mshr_iss_q_if.slave     bus
);
    localparam int PTR_W = $clog2(NUM);
    localparam logic [1:0] MSG_NONE = 2'd0;
    localparam logic [1:0] GET_M    = 2'd2;
    localparam logic [1:0] PUT_M    = 2'd3;

    logic [NUM-1:0]    vld;
    logic [TAG_W-1:0]  tag_q  [NUM];
    logic [IDX_W-1:0]  idx_q  [NUM];
    logic [DATA_W-1:0] data_q [NUM];
    logic [1:0]        msg_q  [NUM];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              head_wrap;
    logic              tail_wrap;

    logic              full;
    logic              empty;
    logic [PTR_W:0]    cnt;
    logic              hit;
    logic [PTR_W-1:0]  hit_ptr;
    logic [DATA_W-1:0] hit_data;
    logic [1:0]        hit_msg;
    logic [PTR_W-1:0]  scan_ptr;
    logic              head_vld;
    logic              drop;
    logic              iss_en;
    logic              retire;
    logic              merge;
    logic              alloc_do;

    assign full  = (head == tail) && (head_wrap != tail_wrap);
    assign empty = (head == tail) && (head_wrap == tail_wrap);
    assign cnt   = {tail_wrap, tail} - {head_wrap, head};

    // Valid entries are contiguous from head, so scanning forward and keeping the last match yields the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_ptr  = '0;
        hit_data = '0;
        hit_msg  = MSG_NONE;
        scan_ptr = '0;
        for (int k = 0; k < NUM; k++) begin
            scan_ptr = head + PTR_W'(k);
            if (vld[scan_ptr] && tag_q[scan_ptr] == bus.alloc_tag_i &&
                idx_q[scan_ptr] == bus.alloc_idx_i) begin
                hit      = 1'b1;
                hit_ptr  = scan_ptr;
                hit_data = data_q[scan_ptr];
                hit_msg  = msg_q[scan_ptr];
            end
        end
    end

    assign head_vld = vld[head];
    assign drop     = head_vld && (msg_q[head] == PUT_M) && !bus.iss_dty_i;
    assign iss_en   = head_vld && !drop;
    assign retire   = (iss_en && bus.iss_ack_i) || drop;
    // The head may already be on the bus, so stores never merge into it.
    assign merge    = bus.alloc_en_i && (bus.alloc_message_i == GET_M) && hit &&
                      (hit_msg == GET_M) && (hit_ptr != head);
    assign alloc_do = bus.alloc_en_i && !merge && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld       <= '0;
            head      <= '0;
            tail      <= '0;
            head_wrap <= 1'b0;
            tail_wrap <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                tag_q[i]  <= '0;
                idx_q[i]  <= '0;
                data_q[i] <= '0;
                msg_q[i]  <= MSG_NONE;
            end
        end else if (bus.flush_i) begin
            vld       <= '0;
            head      <= '0;
            tail      <= '0;
            head_wrap <= 1'b0;
            tail_wrap <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                tag_q[i]  <= '0;
                idx_q[i]  <= '0;
                data_q[i] <= '0;
                msg_q[i]  <= MSG_NONE;
            end
        end else begin
            if (merge) begin
                data_q[hit_ptr] <= bus.alloc_data_i;
            end
            // Retire and allocate never touch the same slot: retire needs a non-empty queue, allocate a non-full one.
            if (retire) begin
                vld[head]    <= 1'b0;
                tag_q[head]  <= '0;
                idx_q[head]  <= '0;
                data_q[head] <= '0;
                msg_q[head]  <= MSG_NONE;
                head         <= head + 1'b1;
                if (head == PTR_W'(NUM - 1)) begin
                    head_wrap <= ~head_wrap;
                end
            end
            if (alloc_do) begin
                vld[tail]    <= 1'b1;
                tag_q[tail]  <= bus.alloc_tag_i;
                idx_q[tail]  <= bus.alloc_idx_i;
                data_q[tail] <= bus.alloc_data_i;
                msg_q[tail]  <= bus.alloc_message_i;
                tail         <= tail + 1'b1;
                if (tail == PTR_W'(NUM - 1)) begin
                    tail_wrap <= ~tail_wrap;
                end
            end
        end
    end

    assign bus.iss_en_o       = iss_en;
    assign bus.iss_st_en_o    = iss_en && (msg_q[head] == GET_M);
    assign bus.iss_evict_en_o = iss_en && (msg_q[head] == PUT_M);
    assign bus.iss_tag_o      = head_vld ? tag_q[head]  : '0;
    assign bus.iss_idx_o      = head_vld ? idx_q[head]  : '0;
    assign bus.iss_data_o     = head_vld ? data_q[head] : '0;
    assign bus.iss_message_o  = head_vld ? msg_q[head]  : MSG_NONE;
    assign bus.iss_head_o     = head;
    assign bus.hit_o          = hit;
    assign bus.hit_data_o     = hit_data;
    assign bus.hit_message_o  = hit_msg;
    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.count_o        = CNT_W'(cnt);
    // A flush discards the request anyway, so it is not reported as an overflow.
    assign bus.ovf_o          = bus.alloc_en_i && !merge && full && !bus.flush_i;
endmodule
